// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side handshake bundle shared by the memory port arbiter.
// The arbiter connects through the master modport and its environment through the slave modport.
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0]   req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [XLEN-1:0]           req_rdata;
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [XLEN-1:0]           mem_wdata;
  logic [XLEN-1:0]           mem_rdata;
  logic                      mem_ready;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, req_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, req_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters, with the grant
// locked across wait states, a stall-cycle counter and a sticky stuck-bus watchdog.
module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  mem_port_arbiter_if.master         bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       timeout_err,
  output logic [31:0]                stall_cycles
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       stall_q, stall_d;

  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  scan_idx;
  logic              found;
  logic [PTR_W-1:0]  sel;
  logic              mem_req_c;
  logic [NUM_REQ-1:0] ready_vec;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [XLEN-1:0]   wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.req_wdata[gi*XLEN +: XLEN];
    end
  endgenerate

  // Modular increment; off never exceeds NUM_REQ-1 so one subtraction suffices.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    winner   = rr_ptr_q;
    scan_idx = rr_ptr_q;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = wrap_inc(rr_ptr_q, i);
      if (!found && bus.req_valid[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    sel        = owner_q;
    mem_req_c  = 1'b0;
    ready_vec  = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          sel       = winner;
          mem_req_c = 1'b1;
          if (bus.mem_ready) begin
            rr_ptr_d = wrap_inc(winner, 1);
          end else begin
            owner_d    = winner;
            wait_cnt_d = CNT_W'(1);
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          rr_ptr_d   = wrap_inc(owner_q, 1);
          wait_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          if (wait_cnt_q < CNT_W'(TIMEOUT)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
          // Flag lands on the same edge the counter reaches TIMEOUT.
          if (wait_cnt_q >= CNT_W'(TIMEOUT - 1)) timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) mem_req_c = 1'b0;
    if (mem_req_c && bus.mem_ready) ready_vec[sel] = 1'b1;

    stall_d = stall_q;
    if (mem_req_c && !bus.mem_ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_req_c & bus.req_we[sel];
  assign bus.mem_addr  = mem_req_c ? addr_arr[sel]  : '0;
  assign bus.mem_wdata = mem_req_c ? wdata_arr[sel] : '0;
  assign bus.req_ready = ready_vec;
  assign bus.req_rdata = bus.mem_rdata;

  assign busy         = (state_q == HOLD) && !rst;
  assign owner_id     = sel;
  assign timeout_err  = timeout_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the 2-requester instance plus
// hand-written sequences for timeout, mid-transaction reset and 4-requester rotation.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .XLEN(32)) bus2();
  mem_port_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .XLEN(32)) bus4();

  logic        busy2, tmo2, busy4, tmo4;
  logic        owner2;
  logic [1:0]  owner4;
  logic [31:0] stall2, stall4;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .XLEN(32), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .busy(busy2), .owner_id(owner2),
    .timeout_err(tmo2), .stall_cycles(stall2)
  );

  mem_port_arbiter #(.NUM_REQ(4), .ADDR_W(32), .XLEN(32), .TIMEOUT(16)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .busy(busy4), .owner_id(owner4),
    .timeout_err(tmo4), .stall_cycles(stall4)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic        mready;
    logic [31:0] mrdata;
    logic        exp_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_rready;
    logic        exp_busy;
    logic        exp_owner;
    logic [31:0] exp_stall;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int exp_o [4];

    rst = 1'b1;
    bus2.req_valid = 2'b11;
    bus2.req_we    = 2'b00;
    bus2.req_addr  = {32'h0000_0300, 32'h0000_0200};
    bus2.req_wdata = {32'd9, 32'd7};
    bus2.mem_rdata = 32'd0;
    bus2.mem_ready = 1'b1;
    bus4.req_valid = 4'b0000;
    bus4.req_we    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus4.req_addr[i*32 +: 32]  = 32'h1000 + 32'(i) * 32'h10;
      bus4.req_wdata[i*32 +: 32] = 32'(i) + 32'd100;
    end
    bus4.mem_rdata = 32'd0;
    bus4.mem_ready = 1'b1;

    //          valid  we     rdy   rdata   req   we    addr      wdata  rready busy  own   stall
    tbl[0]  = '{2'b01, 2'b01, 1'b1, 32'd0, 1'b1, 1'b1, 32'h200, 32'd7, 2'b01, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{2'b10, 2'b00, 1'b1, 32'd0, 1'b1, 1'b0, 32'h300, 32'd9, 2'b10, 1'b0, 1'b1, 32'd0};
    tbl[2]  = '{2'b11, 2'b00, 1'b1, 32'd0, 1'b1, 1'b0, 32'h200, 32'd7, 2'b01, 1'b0, 1'b0, 32'd0};
    tbl[3]  = '{2'b11, 2'b00, 1'b1, 32'd0, 1'b1, 1'b0, 32'h300, 32'd9, 2'b10, 1'b0, 1'b1, 32'd0};
    tbl[4]  = '{2'b11, 2'b00, 1'b1, 32'd0, 1'b1, 1'b0, 32'h200, 32'd7, 2'b01, 1'b0, 1'b0, 32'd0};
    tbl[5]  = '{2'b11, 2'b00, 1'b1, 32'd0, 1'b1, 1'b0, 32'h300, 32'd9, 2'b10, 1'b0, 1'b1, 32'd0};
    tbl[6]  = '{2'b00, 2'b00, 1'b1, 32'd0, 1'b0, 1'b0, 32'h000, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0};
    tbl[7]  = '{2'b11, 2'b00, 1'b0, 32'd7, 1'b1, 1'b0, 32'h200, 32'd7, 2'b00, 1'b0, 1'b0, 32'd0};
    tbl[8]  = '{2'b10, 2'b00, 1'b0, 32'd7, 1'b1, 1'b0, 32'h200, 32'd7, 2'b00, 1'b1, 1'b0, 32'd1};
    tbl[9]  = '{2'b11, 2'b00, 1'b1, 32'd7, 1'b1, 1'b0, 32'h200, 32'd7, 2'b01, 1'b1, 1'b0, 32'd2};
    tbl[10] = '{2'b11, 2'b00, 1'b1, 32'd0, 1'b1, 1'b0, 32'h300, 32'd9, 2'b10, 1'b0, 1'b1, 32'd2};

    // Reset with requests pending: port must stay quiet.
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst.mem_req",   32'(bus2.mem_req),   32'd0);
    chk("rst.req_ready", 32'(bus2.req_ready), 32'd0);
    chk("rst.busy",      32'(busy2),          32'd0);
    chk("rst.stall",     stall2,              32'd0);
    chk("rst.timeout",   32'(tmo2),           32'd0);
    next_cycle();
    rst = 1'b0;

    for (int r = 0; r < NV; r++) begin
      bus2.req_valid = tbl[r].valid;
      bus2.req_we    = tbl[r].we;
      bus2.mem_ready = tbl[r].mready;
      bus2.mem_rdata = tbl[r].mrdata;
      @(negedge clk);
      chk($sformatf("v%0d.mem_req", r),   32'(bus2.mem_req),   32'(tbl[r].exp_req));
      chk($sformatf("v%0d.mem_we", r),    32'(bus2.mem_we),    32'(tbl[r].exp_we));
      chk($sformatf("v%0d.mem_addr", r),  bus2.mem_addr,       tbl[r].exp_addr);
      chk($sformatf("v%0d.mem_wdata", r), bus2.mem_wdata,      tbl[r].exp_wdata);
      chk($sformatf("v%0d.req_ready", r), 32'(bus2.req_ready), 32'(tbl[r].exp_rready));
      chk($sformatf("v%0d.busy", r),      32'(busy2),          32'(tbl[r].exp_busy));
      chk($sformatf("v%0d.owner", r),     32'(owner2),         32'(tbl[r].exp_owner));
      chk($sformatf("v%0d.stall", r),     stall2,              tbl[r].exp_stall);
      chk($sformatf("v%0d.rdata", r),     bus2.req_rdata,      tbl[r].mrdata);
      $display("vec %0d: owner=%0d req_ready=%b addr=%h busy=%0d stall=%0d",
               r, owner2, bus2.req_ready, bus2.mem_addr, busy2, stall2);
      next_cycle();
    end

    // Watchdog: req0 read with ready held low for 20 cycles.
    bus2.req_valid = 2'b01;
    bus2.req_we    = 2'b00;
    bus2.mem_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("tmo.k%0d.err", k),  32'(tmo2),  32'(k >= 17));
      chk($sformatf("tmo.k%0d.busy", k), 32'(busy2), 32'(k >= 2));
      next_cycle();
    end
    bus2.mem_ready = 1'b1;
    @(negedge clk);
    chk("tmo.done.req_ready", 32'(bus2.req_ready), 32'd1);
    chk("tmo.done.err",       32'(tmo2),           32'd1);
    chk("tmo.done.stall",     stall2,              32'd22);
    $display("timeout txn: req_ready=%b timeout_err=%0d stall=%0d", bus2.req_ready, tmo2, stall2);
    next_cycle();
    bus2.req_valid = 2'b00;
    @(negedge clk);
    chk("tmo.sticky", 32'(tmo2), 32'd1);
    next_cycle();

    // Reset in the middle of a held transaction owned by req1.
    bus2.req_valid = 2'b11;
    bus2.mem_ready = 1'b0;
    @(negedge clk);
    chk("mid.grant_owner", 32'(owner2), 32'd1);
    next_cycle();
    rst = 1'b1;
    bus2.mem_ready = 1'b1;
    @(negedge clk);
    chk("mid.rst.req_ready", 32'(bus2.req_ready), 32'd0);
    chk("mid.rst.mem_req",   32'(bus2.mem_req),   32'd0);
    chk("mid.rst.busy",      32'(busy2),          32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid.after.req_ready", 32'(bus2.req_ready), 32'd1);
    chk("mid.after.owner",     32'(owner2),         32'd0);
    chk("mid.after.stall",     stall2,              32'd0);
    chk("mid.after.err",       32'(tmo2),           32'd0);
    chk("mid.after.busy",      32'(busy2),          32'd0);
    $display("after reset: owner=%0d req_ready=%b", owner2, bus2.req_ready);
    next_cycle();
    bus2.req_valid = 2'b00;

    // Four requesters: walk rr_ptr to 2 via req1, then only req3 and req1 compete.
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    bus4.req_valid = 4'b0010;
    bus4.mem_ready = 1'b1;
    @(negedge clk);
    chk("n4.pre.owner",     32'(owner4),         32'd1);
    chk("n4.pre.req_ready", 32'(bus4.req_ready), 32'd2);
    next_cycle();
    exp_o = '{3, 1, 3, 1};
    bus4.req_valid = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("n4.g%0d.owner", j),     32'(owner4),         32'(exp_o[j]));
      chk($sformatf("n4.g%0d.req_ready", j), 32'(bus4.req_ready), 32'd1 << exp_o[j]);
      chk($sformatf("n4.g%0d.addr", j),      bus4.mem_addr,       32'h1000 + 32'(exp_o[j]) * 32'h10);
      $display("n4 grant %0d: owner=%0d req_ready=%b addr=%h", j, owner4, bus4.req_ready, bus4.mem_addr);
      next_cycle();
    end
    bus4.req_valid = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
